result_display: RTL and testbench

//  Downstream stage of the calculator: consumes the 16-bit product and its load strobe
//  (result/ld_result) and shows the value in decimal on the 4-digit multiplexed 7-seg display.

---
 rtl/result_display_if.sv | 22 ++
 rtl/result_display.sv | 217 +++++++++++++++++++++
 tb/tb_result_display.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_display_if.sv
// result_display_if: calculator-result handshake plus the display/status outputs of result_display.
// master drives the product and its strobe; slave (the display block) drives everything else.
interface result_display_if;
  logic [15:0] result;
  logic        ld_result;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;
  logic [15:0] bcd;

  modport master (
    output result, ld_result,
    input  an, seg, dp, busy, ovf, bcd
  );

  modport slave (
    input  result, ld_result,
    output an, seg, dp, busy, ovf, bcd
  );
endinterface

// File: rtl/result_display.sv
// result_display: 16-bit binary -> decimal via one-shift-per-clock double-dabble, shown on a 4-digit
// multiplexed 7-seg display. Optional macro LEAD_ZERO_BLANK_EN blanks leading-zero digits.
module result_display #(
  parameter int REFRESH_BITS = 16
) (
  input logic             clk,
  input logic             rst_n,
  result_display_if.slave bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CONV       = 2'd1;
  localparam logic [1:0] LOAD       = 2'd2;
  localparam logic [4:0] LAST_SHIFT = 5'd15;

  // One double-dabble iteration: +3 on every nibble >= 5, then shift in the next binary bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] acc, input logic msb);
    logic [19:0] adj;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return {adj[18:0], msb};
  endfunction

  function automatic logic [6:0] seg7_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
    return glyph;
  endfunction

  logic [1:0]              state_r;
  logic [15:0]             sh_r;
  logic [19:0]             acc_r;
  logic [4:0]              cnt_r;
  logic                    pend_valid_r;
  logic [15:0]             pend_val_r;
  logic                    busy_r;
  logic [15:0]             bcd_r;
  logic                    ovf_r;
  logic [REFRESH_BITS-1:0] rc_r;
  logic [3:0]              an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;

  logic                    restart_s;
  logic [15:0]             restart_val_s;
  logic [1:0]              digit_sel_s;
  logic [3:0]              nibble_s;
  logic                    blank_s;
  logic [3:0]              an_s;
  logic [6:0]              seg_s;

  // A strobe arriving in the LOAD cycle is newer than anything pending, so it wins.
  always_comb begin
    restart_s = bus.ld_result | pend_valid_r;
    if (bus.ld_result) begin
      restart_val_s = bus.result;
    end else begin
      restart_val_s = pend_val_r;
    end
  end

  // Conversion FSM; bcd/ovf only change in LOAD, so the display never sees a partial value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sh_r         <= 16'd0;
      acc_r        <= 20'd0;
      cnt_r        <= 5'd0;
      pend_valid_r <= 1'b0;
      pend_val_r   <= 16'd0;
      busy_r       <= 1'b0;
      bcd_r        <= 16'd0;
      ovf_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pend_valid_r <= 1'b0;
          if (bus.ld_result) begin
            sh_r    <= bus.result;
            acc_r   <= 20'd0;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b1;
            state_r <= CONV;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        CONV: begin
          acc_r <= dabble_step(acc_r, sh_r[15]);
          sh_r  <= {sh_r[14:0], 1'b0};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST_SHIFT) begin
            state_r <= LOAD;
          end else begin
            state_r <= CONV;
          end
          if (bus.ld_result) begin
            pend_valid_r <= 1'b1;
            pend_val_r   <= bus.result;
          end else begin
            pend_valid_r <= pend_valid_r;
          end
        end
        LOAD: begin
          bcd_r        <= acc_r[15:0];
          ovf_r        <= (acc_r[19:16] != 4'd0);
          pend_valid_r <= 1'b0;
          if (restart_s) begin
            sh_r    <= restart_val_s;
            acc_r   <= 20'd0;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b1;
            state_r <= CONV;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          pend_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign digit_sel_s = rc_r[REFRESH_BITS-1 -: 2];

  // Digit select and leading-zero detection from the currently displayed value.
  always_comb begin
    case (digit_sel_s)
      2'd0: begin
        an_s     = 4'b1110;
        nibble_s = bcd_r[3:0];
      end
      2'd1: begin
        an_s     = 4'b1101;
        nibble_s = bcd_r[7:4];
      end
      2'd2: begin
        an_s     = 4'b1011;
        nibble_s = bcd_r[11:8];
      end
      2'd3: begin
        an_s     = 4'b0111;
        nibble_s = bcd_r[15:12];
      end
      default: begin
        an_s     = 4'b1111;
        nibble_s = 4'd0;
      end
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    case (digit_sel_s)
      2'd3:    blank_s = (bcd_r[15:12] == 4'd0);
      2'd2:    blank_s = (bcd_r[15:8] == 8'd0);
      2'd1:    blank_s = (bcd_r[15:4] == 12'd0);
      default: blank_s = 1'b0;
    endcase
    if (ovf_r) begin
      blank_s = 1'b0;
    end else begin
      blank_s = blank_s;
    end
`else
    blank_s = 1'b0;
`endif
    if (ovf_r) begin
      seg_s = 7'b0111111;
    end else if (blank_s) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg7_glyph(nibble_s);
    end
  end

  // an and seg share one register stage so the enabled digit and its segments always match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_r  <= '0;
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      rc_r  <= rc_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= 1'b1;
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;
  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (REFRESH_BITS=4) against an arithmetic reference model.
module tb_result_display;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_display_if bus();

  result_display #(.REFRESH_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: integer value shown, cycles left until it is loaded, one pending slot.
  bit         m_busy;
  int         m_left;
  int         m_cur;
  bit         m_pend;
  int         m_pend_val;
  int         m_disp;
  int         m_rc;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] ref_glyph(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'((v / 1) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int disp, input int digit);
    int p10 [4];
    p10 = '{1, 10, 100, 1000};
    if (disp > 9999) return 7'b0111111;
`ifdef LEAD_ZERO_BLANK_EN
    if (digit > 0 && disp < p10[digit]) return 7'b1111111;
`endif
    return ref_glyph((disp / p10[digit]) % 10);
  endfunction

  task automatic start_model(input int v);
    m_busy = 1'b1;
    m_cur  = v;
    m_left = 17;
  endtask

  // Drive inputs for one clock, then advance the model to the post-edge state.
  task automatic tick(input bit ld, input logic [15:0] val);
    @(negedge clk);
    bus.ld_result = ld;
    bus.result    = val;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_left = 0; m_pend = 1'b0; m_disp = 0; m_rc = 0;
      m_an = 4'b1111; m_seg = 7'b1111111;
    end else begin
      m_an = 4'b1111;
      m_an[m_rc / 4] = 1'b0;
      m_seg = ref_seg(m_disp, m_rc / 4);
      m_rc = (m_rc + 1) % 16;
      if (!m_busy) begin
        if (ld) start_model(int'(val));
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_cur;
          if (ld) start_model(int'(val));
          else if (m_pend) start_model(m_pend_val);
          else m_busy = 1'b0;
          m_pend = 1'b0;
        end else if (ld) begin
          m_pend = 1'b1;
          m_pend_val = int'(val);
        end
      end
    end
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && m_busy; i++) tick(1'b0, 16'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b0, 16'd0);
    tick(1'b0, 16'd0);
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", bus.dp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd got=%h exp=0000", bus.bcd); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_conversion(input logic [15:0] val, input logic [15:0] exp_bcd,
                                 input logic exp_ovf, input logic [6:0] exp_d0_seg);
    wait_idle();
    tick(1'b1, val);
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL conv_busy val=%0d cyc=%0d got=%b exp=1", val, i, bus.busy); end
      tick(1'b0, 16'd0);
      checks++;
      if (bus.bcd !== ref_bcd(m_disp)) begin errors++; $display("FAIL conv_bcd val=%0d cyc=%0d got=%h exp=%h", val, i, bus.bcd, ref_bcd(m_disp)); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL conv_done_busy val=%0d got=%b exp=0", val, bus.busy); end
    checks++; if (bus.bcd !== exp_bcd) begin errors++; $display("FAIL conv_result val=%0d got=%h exp=%h", val, bus.bcd, exp_bcd); end
    checks++; if (bus.ovf !== exp_ovf) begin errors++; $display("FAIL conv_ovf val=%0d got=%b exp=%b", val, bus.ovf, exp_ovf); end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 16'd0);
      checks++;
      if (bus.an !== m_an || bus.seg !== m_seg) begin
        errors++; $display("FAIL conv_display val=%0d got an=%b seg=%b exp an=%b seg=%b", val, bus.an, bus.seg, m_an, m_seg);
      end
      if (bus.an == 4'b1110) begin
        checks++;
        if (bus.seg !== exp_d0_seg) begin errors++; $display("FAIL conv_digit0 val=%0d got=%b exp=%b", val, bus.seg, exp_d0_seg); end
      end
      if (exp_ovf) begin
        checks++;
        if (bus.seg !== 7'b0111111) begin errors++; $display("FAIL conv_dash val=%0d got=%b exp=0111111", val, bus.seg); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen_42;
    seen_42 = 1'b0;
    wait_idle();
    tick(1'b1, 16'd42);
    tick(1'b0, 16'd0); tick(1'b0, 16'd0); tick(1'b0, 16'd0);
    tick(1'b1, 16'd9999);
    tick(1'b0, 16'd0); tick(1'b0, 16'd0);
    tick(1'b1, 16'd1234);
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 16'd0);
      checks++;
      if (bus.bcd !== ref_bcd(m_disp) || bus.busy !== m_busy) begin
        errors++; $display("FAIL b2b_track cyc=%0d got bcd=%h busy=%b exp bcd=%h busy=%b", i, bus.bcd, bus.busy, ref_bcd(m_disp), m_busy);
      end
      checks++;
      if (bus.bcd === 16'h9999) begin errors++; $display("FAIL b2b_dropped got=%h exp=not 9999", bus.bcd); end
      if (bus.bcd === 16'h0042 && !seen_42) begin
        seen_42 = 1'b1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_held got=%b exp=1", bus.busy); end
      end
    end
    checks++; if (!seen_42) begin errors++; $display("FAIL b2b_first got=never exp=0042"); end
    checks++; if (bus.bcd !== 16'h1234) begin errors++; $display("FAIL b2b_last got=%h exp=1234", bus.bcd); end
  endtask

  task automatic test_refresh();
    logic [3:0] prev;
    int run;
    prev = bus.an;
    run = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 16'd0);
      checks++;
      if (bus.an !== m_an) begin errors++; $display("FAIL refresh_an cyc=%0d got=%b exp=%b", i, bus.an, m_an); end
      if (bus.an !== prev) begin
        checks++;
        if (bus.an !== {prev[2:0], prev[3]}) begin errors++; $display("FAIL refresh_order got=%b exp=%b", bus.an, {prev[2:0], prev[3]}); end
        if (i > 4) begin
          checks++;
          if (run != 4) begin errors++; $display("FAIL refresh_dwell got=%0d exp=4", run); end
        end
        run = 0;
      end
      run++;
      prev = bus.an;
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    tick(1'b1, 16'd8765);
    for (int i = 0; i < 7; i++) tick(1'b0, 16'd0);
    rst_n = 1'b0;
    tick(1'b0, 16'd0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.bcd !== 16'h0000) begin errors++; $display("FAIL midrst_bcd got=%h exp=0000", bus.bcd); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'd0);
      checks++;
      if (bus.bcd !== 16'h0000 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL midrst_abort got bcd=%h busy=%b exp bcd=0000 busy=0", bus.bcd, bus.busy);
      end
    end
    test_conversion(16'd321, 16'h0321, 1'b0, 7'b1111001);
  endtask

  task automatic test_blank();
    logic [6:0] exp_hi;
`ifdef LEAD_ZERO_BLANK_EN
    exp_hi = 7'b1111111;
`else
    exp_hi = 7'b1000000;
`endif
    test_conversion(16'd7, 16'h0007, 1'b0, 7'b1111000);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 16'd0);
      if (bus.an != 4'b1110) begin
        checks++;
        if (bus.seg !== exp_hi) begin errors++; $display("FAIL blank_upper an=%b got=%b exp=%b", bus.an, bus.seg, exp_hi); end
      end
    end
  endtask

  task automatic test_random();
    bit ld;
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 5) == 0);
      v  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      tick(ld, v);
      checks++;
      if (bus.bcd !== ref_bcd(m_disp) || bus.ovf !== (m_disp > 9999) || bus.busy !== m_busy) begin
        errors++; $display("FAIL rand_status cyc=%0d got bcd=%h ovf=%b busy=%b exp bcd=%h ovf=%b busy=%b",
                           i, bus.bcd, bus.ovf, bus.busy, ref_bcd(m_disp), (m_disp > 9999), m_busy);
      end
      checks++;
      if (bus.an !== m_an || bus.seg !== m_seg || bus.dp !== 1'b1) begin
        errors++; $display("FAIL rand_display cyc=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                           i, bus.an, bus.seg, bus.dp, m_an, m_seg);
      end
    end
  endtask

  initial begin
    bus.result    = 16'd0;
    bus.ld_result = 1'b0;
    rst_n         = 1'b0;
    m_busy = 1'b0; m_left = 0; m_cur = 0; m_pend = 1'b0; m_pend_val = 0;
    m_disp = 0; m_rc = 0; m_an = 4'b1111; m_seg = 7'b1111111;
    test_reset();
    test_conversion(16'd4005, 16'h4005, 1'b0, 7'b0010010);
    test_conversion(16'd65535, 16'h5535, 1'b1, 7'b0111111);
    test_back_to_back();
    test_refresh();
    test_reset_mid();
    test_blank();
    test_conversion(16'd10000, 16'h0000, 1'b1, 7'b0111111);
    test_conversion(16'd9999, 16'h9999, 1'b0, 7'b0010000);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
